// File: rtl/wb_dcache_pkg.sv
// Shared definitions for the write-back L1 data cache: geometry, interface structs and controller states.
package wb_dcache_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned DCACHE_SETS       = 256;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned OFFSET_W          = 4;
  localparam int unsigned INDEX_W           = 8;
  localparam int unsigned TAG_W             = XLEN - INDEX_W - OFFSET_W;
  localparam int unsigned WORDS_PER_LINE    = DCACHE_LINE_WIDTH / XLEN;

  typedef logic [INDEX_W-1:0]           idx_t;
  typedef logic [TAG_W-1:0]             tag_t;
  typedef logic [DCACHE_LINE_WIDTH-1:0] line_t;

  typedef struct packed {
    logic            req;
    logic            w_en;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] w_data;
    logic [3:0]      sel_byte;
  } lsu_req_t;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] r_data;
  } lsu_rsp_t;

  typedef struct packed {
    logic  ack;
    line_t r_data;
  } mem_rsp_t;

  typedef struct packed {
    logic            req;
    logic            w_en;
    logic [XLEN-1:0] addr;
    line_t           w_data;
  } mem_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_FLUSH,
    ST_FLUSH_WB,
    ST_FLUSH_DONE
  } dcache_state_e;

  // A zero byte-select from the LSU means a full-word store.
  function automatic logic [3:0] eff_byte_sel(input logic [3:0] sel);
    return (sel == 4'h0) ? 4'hF : sel;
  endfunction

endpackage

// File: rtl/wb_dcache_controller.sv
// Cache control FSM: hit/miss sequencing, victim writeback, refill, flush walk and kill handling.
module wb_dcache_controller
  import wb_dcache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_access,
  input  logic i_w_en,
  input  logic i_hit,
  input  logic i_victim_dirty,
  input  logic i_flush,
  input  logic i_kill,
  input  logic i_mem_ack,
  input  logic i_flush_line_dirty,
  output logic o_lsu_ack,
  output logic o_mem_req,
  output logic o_mem_w_en,
  output logic o_mem_kill,
  output logic o_hit_wr,
  output logic o_refill,
  output logic o_clr_dirty,
  output logic o_flush_mode,
  output idx_t o_flush_idx
);

  dcache_state_e r_state, w_state_nxt;
  idx_t          r_flush_idx, w_flush_idx_nxt;
  logic          r_flush_done, w_flush_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_flush_idx  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_idx  <= w_flush_idx_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

  // r_flush_done blocks a second flush until the request level has dropped.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_idx_nxt  = r_flush_idx;
    w_flush_done_nxt = r_flush_done & i_flush;
    o_lsu_ack        = 1'b0;
    o_mem_req        = 1'b0;
    o_mem_w_en       = 1'b0;
    o_mem_kill       = 1'b0;
    o_hit_wr         = 1'b0;
    o_refill         = 1'b0;
    o_clr_dirty      = 1'b0;
    o_flush_mode     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_flush && !r_flush_done) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_idx_nxt = '0;
        end else if (i_access && !i_kill) begin
          if (i_hit) begin
            o_lsu_ack = 1'b1;
            o_hit_wr  = i_w_en;
          end else if (i_victim_dirty) begin
            w_state_nxt = ST_WRITEBACK;
          end else begin
            w_state_nxt = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        if (i_kill) begin
          o_mem_kill  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          o_mem_req  = 1'b1;
          o_mem_w_en = 1'b1;
          if (i_mem_ack) begin
            o_clr_dirty = 1'b1;
            w_state_nxt = ST_ALLOCATE;
          end
        end
      end
      ST_ALLOCATE: begin
        if (i_kill) begin
          o_mem_kill  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          o_mem_req = 1'b1;
          if (i_mem_ack) begin
            o_refill    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        o_flush_mode = 1'b1;
        if (i_flush_line_dirty) begin
          w_state_nxt = ST_FLUSH_WB;
        end else if (r_flush_idx == idx_t'(DCACHE_SETS - 1)) begin
          w_state_nxt = ST_FLUSH_DONE;
        end else begin
          w_flush_idx_nxt = r_flush_idx + idx_t'(1);
        end
      end
      ST_FLUSH_WB: begin
        o_flush_mode = 1'b1;
        o_mem_req    = 1'b1;
        o_mem_w_en   = 1'b1;
        if (i_mem_ack) begin
          o_clr_dirty = 1'b1;
          if (r_flush_idx == idx_t'(DCACHE_SETS - 1)) begin
            w_state_nxt = ST_FLUSH_DONE;
          end else begin
            w_flush_idx_nxt = r_flush_idx + idx_t'(1);
            w_state_nxt     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH_DONE: begin
        o_lsu_ack        = 1'b1;
        w_flush_done_nxt = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_flush_idx = r_flush_idx;

endmodule

// File: rtl/wb_dcache_top.sv
// Direct-mapped write-back/write-allocate L1 data cache: arrays, hit compare and word/byte datapath.
module wb_dcache_top
  import wb_dcache_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     dmem_sel_i,
  input  logic     dcache_flush_i,
  input  logic     dcache_kill_i,
  input  lsu_req_t lsummu2dcache_i,
  output lsu_rsp_t dcache2lsummu_o,
  input  mem_rsp_t mem2dcache_i,
  output mem_req_t dcache2mem_o,
  output logic     dcache2mem_kill_o
);

  tag_t                   r_tag  [DCACHE_SETS];
  line_t                  r_line [DCACHE_SETS];
  logic [DCACHE_SETS-1:0] r_valid;
  logic [DCACHE_SETS-1:0] r_dirty;

  idx_t       w_idx, w_flush_idx, w_arr_idx;
  tag_t       w_tag;
  logic [1:0] w_word;
  logic [3:0] w_bsel;
  line_t      w_cur_line, w_wr_line;
  logic       w_access, w_hit, w_victim_dirty, w_flush_line_dirty;
  logic       w_lsu_ack, w_mem_req, w_mem_w_en, w_hit_wr, w_refill, w_clr_dirty, w_flush_mode;
  logic       w_unused_addr_lsb;

  assign w_idx              = lsummu2dcache_i.addr[11:4];
  assign w_tag              = lsummu2dcache_i.addr[31:12];
  assign w_word             = lsummu2dcache_i.addr[3:2];
  assign w_unused_addr_lsb  = ^lsummu2dcache_i.addr[1:0];
  assign w_bsel             = eff_byte_sel(lsummu2dcache_i.sel_byte);
  assign w_access           = lsummu2dcache_i.req & dmem_sel_i;
  assign w_hit              = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty     = r_valid[w_idx] & r_dirty[w_idx];
  assign w_flush_line_dirty = r_valid[w_flush_idx] & r_dirty[w_flush_idx];
  assign w_arr_idx          = w_flush_mode ? w_flush_idx : w_idx;
  assign w_cur_line         = r_line[w_idx];

  always_comb begin
    w_wr_line = w_cur_line;
    for (int b = 0; b < 4; b++) begin
      if (w_bsel[b]) begin
        w_wr_line[int'(w_word)*XLEN + b*8 +: 8] = lsummu2dcache_i.w_data[b*8 +: 8];
      end
    end
  end

  wb_dcache_controller u_ctrl (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_access           (w_access),
    .i_w_en             (lsummu2dcache_i.w_en),
    .i_hit              (w_hit),
    .i_victim_dirty     (w_victim_dirty),
    .i_flush            (dcache_flush_i),
    .i_kill             (dcache_kill_i),
    .i_mem_ack          (mem2dcache_i.ack),
    .i_flush_line_dirty (w_flush_line_dirty),
    .o_lsu_ack          (w_lsu_ack),
    .o_mem_req          (w_mem_req),
    .o_mem_w_en         (w_mem_w_en),
    .o_mem_kill         (dcache2mem_kill_o),
    .o_hit_wr           (w_hit_wr),
    .o_refill           (w_refill),
    .o_clr_dirty        (w_clr_dirty),
    .o_flush_mode       (w_flush_mode),
    .o_flush_idx        (w_flush_idx)
  );

  // Tag and data storage carry no reset; valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_line[w_idx] <= mem2dcache_i.r_data;
      r_tag[w_idx]  <= w_tag;
    end else if (w_hit_wr) begin
      r_line[w_idx] <= w_wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_refill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_hit_wr) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_clr_dirty) begin
        r_dirty[w_arr_idx] <= 1'b0;
      end
    end
  end

  assign dcache2lsummu_o.ack    = w_lsu_ack;
  assign dcache2lsummu_o.r_data = w_cur_line[int'(w_word)*XLEN +: XLEN];

  // Writebacks target the victim's own address; refills target the requested line.
  assign dcache2mem_o.req    = w_mem_req;
  assign dcache2mem_o.w_en   = w_mem_w_en;
  assign dcache2mem_o.addr   = w_mem_w_en ? {r_tag[w_arr_idx], w_arr_idx, 4'b0000}
                                          : {lsummu2dcache_i.addr[31:4], 4'b0000};
  assign dcache2mem_o.w_data = r_line[w_arr_idx];

endmodule

// File: tb/tb_wb_dcache_top.sv
// Directed bench for wb_dcache_top with a small line-based memory model.
module tb_wb_dcache_top;
  import wb_dcache_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     dmem_sel = 1'b0;
  logic     flush = 1'b0;
  logic     kill = 1'b0;
  logic     kill_o;
  lsu_req_t lsu = '0;
  lsu_rsp_t rsp;
  mem_rsp_t m2d = '0;
  mem_req_t d2m;

  int total = 0;
  int bad = 0;
  int req_cycles = 0;
  int mcnt = 0;
  logic [127:0] store [logic [27:0]];
  logic [31:0]  wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  logic [31:0]  alloc_q[$];

  always #5 clk = ~clk;

  wb_dcache_top dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dmem_sel_i        (dmem_sel),
    .dcache_flush_i    (flush),
    .dcache_kill_i     (kill),
    .lsummu2dcache_i   (lsu),
    .dcache2lsummu_o   (rsp),
    .mem2dcache_i      (m2d),
    .dcache2mem_o      (d2m),
    .dcache2mem_kill_o (kill_o)
  );

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    if (store.exists(a[31:4])) return store[a[31:4]];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = ({a[31:4], 4'b0000} + 32'(4*k)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  // Memory answers after three request cycles with a one-cycle ack.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2d.ack = 1'b0;
      mcnt = 0;
    end else if (m2d.ack) begin
      m2d.ack = 1'b0;
      mcnt = 0;
    end else if (d2m.req && !kill_o) begin
      mcnt++;
      if (mcnt == 3) begin
        m2d.ack = 1'b1;
        mcnt = 0;
        if (d2m.w_en) begin
          store[d2m.addr[31:4]] = d2m.w_data;
          wb_addr_q.push_back(d2m.addr);
          wb_data_q.push_back(d2m.w_data);
        end else begin
          m2d.r_data = mem_line(d2m.addr);
          alloc_q.push_back(d2m.addr);
        end
      end
    end else begin
      mcnt = 0;
    end
    if (d2m.req) req_cycles++;
  end

  task automatic lsu_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] sel, output logic [31:0] rd, output int cyc,
                            output bit ok);
    @(negedge clk);
    dmem_sel = 1'b1;
    lsu.req = 1'b1; lsu.w_en = w; lsu.addr = a; lsu.w_data = wd; lsu.sel_byte = sel;
    cyc = 0;
    #1;
    while (!rsp.ack && cyc < 300) begin
      @(negedge clk); #1; cyc++;
    end
    ok = rsp.ack;
    rd = rsp.r_data;
    @(posedge clk); #1;
    lsu.req = 1'b0; lsu.w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (rsp.ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", rsp.ack); end
    total++; if (d2m.req !== 1'b0 || d2m.w_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_memreq: got req=%b wen=%b want 0/0", d2m.req, d2m.w_en); end
    total++; if (kill_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_kill: got %b want 0", kill_o); end
    total++; if (dut.r_valid !== '0 || dut.r_dirty !== '0) begin bad++; $display("[TB] FAIL reset_vd: valid/dirty not cleared"); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_line_reads(input logic [31:0] base, input string nm);
    logic [31:0] rd; int cyc; bit ok; int na; int rc;
    na = alloc_q.size();
    lsu_access(1'b0, base, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL %s_miss_ack: no ack within bound", nm); end
    total++; if (rd !== (base ^ 32'h5A5A_0000)) begin bad++; $display("[TB] FAIL %s_miss_data: got %h want %h", nm, rd, base ^ 32'h5A5A_0000); end
    total++; if (alloc_q.size() != na + 1 || alloc_q[$] !== base) begin bad++; $display("[TB] FAIL %s_alloc: count %0d want %0d", nm, alloc_q.size(), na + 1); end
    for (int i = 1; i < 4; i++) begin
      rc = req_cycles;
      lsu_access(1'b0, base + 32'(4*i), 32'h0, 4'h0, rd, cyc, ok);
      total++; if (rd !== ((base + 32'(4*i)) ^ 32'h5A5A_0000) || cyc != 0) begin bad++; $display("[TB] FAIL %s_hit%0d: got %h lat %0d want %h lat 0", nm, i, rd, cyc, (base + 32'(4*i)) ^ 32'h5A5A_0000); end
      total++; if (req_cycles != rc) begin bad++; $display("[TB] FAIL %s_hit%0d_traffic: got %0d req cycles want 0", nm, i, req_cycles - rc); end
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int cyc; bit ok; int rc;
    rc = req_cycles;
    lsu_access(1'b1, 32'h14, 32'h4, 4'hF, rd, cyc, ok);
    total++; if (!ok || cyc != 0) begin bad++; $display("[TB] FAIL wr_ack: got ok=%b lat=%0d want 1/0", ok, cyc); end
    lsu_access(1'b0, 32'h14, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h4) begin bad++; $display("[TB] FAIL wr_readback: got %h want 00000004", rd); end
    total++; if (dut.r_dirty[1] !== 1'b1) begin bad++; $display("[TB] FAIL wr_dirty: got %b want 1", dut.r_dirty[1]); end
    total++; if (req_cycles != rc) begin bad++; $display("[TB] FAIL wr_traffic: got %0d req cycles want 0", req_cycles - rc); end
    lsu_access(1'b1, 32'h18, 32'hAABB_CCDD, 4'b0010, rd, cyc, ok);
    lsu_access(1'b0, 32'h18, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h5A5A_CC18) begin bad++; $display("[TB] FAIL wr_byte: got %h want 5a5acc18", rd); end
    lsu_access(1'b1, 32'h1C, 32'h1122_3344, 4'h0, rd, cyc, ok);
    lsu_access(1'b0, 32'h1C, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h1122_3344) begin bad++; $display("[TB] FAIL wr_sel0: got %h want 11223344", rd); end
  endtask

  task automatic test_evict();
    logic [31:0] rd; int cyc; bit ok; int nw; int na; int rc;
    nw = wb_addr_q.size(); na = alloc_q.size();
    lsu_access(1'b0, 32'hC000_0010, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (!ok || rd !== 32'h9A5A_0010) begin bad++; $display("[TB] FAIL ev_data: got %h want 9a5a0010", rd); end
    total++; if (wb_addr_q.size() != nw + 1 || wb_addr_q[$] !== 32'h10) begin bad++; $display("[TB] FAIL ev_wb_addr: count %0d want %0d", wb_addr_q.size(), nw + 1); end
    total++; if (wb_data_q[$] !== {32'h1122_3344, 32'h5A5A_CC18, 32'h0000_0004, 32'h5A5A_0010}) begin bad++; $display("[TB] FAIL ev_wb_data: got %h", wb_data_q[$]); end
    total++; if (alloc_q.size() != na + 1 || alloc_q[$] !== 32'hC000_0010) begin bad++; $display("[TB] FAIL ev_alloc: got %h want c0000010", alloc_q[$]); end
    total++; if (dut.r_dirty[1] !== 1'b0) begin bad++; $display("[TB] FAIL ev_dirty: got %b want 0", dut.r_dirty[1]); end
    rc = req_cycles;
    for (int i = 1; i < 4; i++) begin
      lsu_access(1'b0, 32'hC000_0010 + 32'(4*i), 32'h0, 4'h0, rd, cyc, ok);
      total++; if (rd !== (32'h9A5A_0010 + 32'(4*i)) || cyc != 0) begin bad++; $display("[TB] FAIL ev_hit%0d: got %h lat %0d", i, rd, cyc); end
    end
    total++; if (req_cycles != rc) begin bad++; $display("[TB] FAIL ev_hit_traffic: got %0d req cycles want 0", req_cycles - rc); end
    lsu_access(1'b0, 32'h14, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h4 || wb_addr_q.size() != nw + 1) begin bad++; $display("[TB] FAIL ev_refetch: got %h wbs %0d want 00000004 %0d", rd, wb_addr_q.size(), nw + 1); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; int cyc; bit ok; int nw;
    lsu_access(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, rd, cyc, ok);
    lsu_access(1'b1, 32'h34, 32'h1234_5678, 4'hF, rd, cyc, ok);
    total++; if (dut.r_dirty[3:0] !== 4'b1100) begin bad++; $display("[TB] FAIL fl_pre_dirty: got %b want 1100", dut.r_dirty[3:0]); end
    nw = wb_addr_q.size();
    @(negedge clk);
    flush = 1'b1;
    cyc = 0;
    #1;
    while (!rsp.ack && cyc < 3000) begin
      @(negedge clk); #1; cyc++;
    end
    total++; if (rsp.ack !== 1'b1) begin bad++; $display("[TB] FAIL fl_ack: no ack within bound"); end
    @(negedge clk); #1;
    total++; if (rsp.ack !== 1'b0 || d2m.req !== 1'b0) begin bad++; $display("[TB] FAIL fl_pulse: got ack=%b req=%b want 0/0", rsp.ack, d2m.req); end
    repeat (5) @(negedge clk);
    total++; if (wb_addr_q.size() != nw + 2) begin bad++; $display("[TB] FAIL fl_wb_count: got %0d want 2", wb_addr_q.size() - nw); end
    else begin
      total++; if (wb_addr_q[nw] !== 32'h20 || wb_addr_q[nw+1] !== 32'h30) begin bad++; $display("[TB] FAIL fl_wb_addr: got %h %h want 20 30", wb_addr_q[nw], wb_addr_q[nw+1]); end
      total++; if (wb_data_q[nw][31:0] !== 32'hDEAD_BEEF || wb_data_q[nw+1][63:32] !== 32'h1234_5678) begin bad++; $display("[TB] FAIL fl_wb_data: got %h %h", wb_data_q[nw][31:0], wb_data_q[nw+1][63:32]); end
    end
    total++; if (dut.r_dirty !== '0) begin bad++; $display("[TB] FAIL fl_dirty: dirty bits not all clear"); end
    total++; if (dut.r_valid[3:0] !== 4'hF) begin bad++; $display("[TB] FAIL fl_valid: got %b want 1111", dut.r_valid[3:0]); end
    flush = 1'b0;
    lsu_access(1'b0, 32'h20, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'hDEAD_BEEF || cyc != 0) begin bad++; $display("[TB] FAIL fl_hit_after: got %h lat %0d want deadbeef 0", rd, cyc); end
  endtask

  task automatic test_kill();
    logic [31:0] rd; int cyc; bit ok; int na;
    na = alloc_q.size();
    @(negedge clk);
    lsu.req = 1'b1; lsu.w_en = 1'b0; lsu.addr = 32'h40; lsu.sel_byte = 4'h0;
    cyc = 0;
    #1;
    while (!d2m.req && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    total++; if (d2m.req !== 1'b1) begin bad++; $display("[TB] FAIL kill_start: no mem req within bound"); end
    kill = 1'b1; lsu.req = 1'b0;
    #1;
    total++; if (kill_o !== 1'b1 || d2m.req !== 1'b0 || rsp.ack !== 1'b0) begin bad++; $display("[TB] FAIL kill_out: got kill=%b req=%b ack=%b want 1/0/0", kill_o, d2m.req, rsp.ack); end
    @(posedge clk); #1;
    kill = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (dut.r_valid[4] !== 1'b0 || alloc_q.size() != na) begin bad++; $display("[TB] FAIL kill_noupd: valid=%b allocs=%0d want 0/%0d", dut.r_valid[4], alloc_q.size(), na); end
    lsu_access(1'b0, 32'h40, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h5A5A_0040 || alloc_q.size() != na + 1) begin bad++; $display("[TB] FAIL kill_refetch: got %h allocs %0d want 5a5a0040 %0d", rd, alloc_q.size(), na + 1); end
  endtask

  task automatic test_idle_kill_and_sel();
    logic [31:0] rd; int cyc; bit ok; int rc;
    @(negedge clk);
    kill = 1'b1;
    lsu.req = 1'b1; lsu.w_en = 1'b1; lsu.addr = 32'h0; lsu.w_data = 32'hFFFF_FFFF; lsu.sel_byte = 4'hF;
    #1;
    total++; if (rsp.ack !== 1'b0) begin bad++; $display("[TB] FAIL ikill_ack: got %b want 0", rsp.ack); end
    @(posedge clk); #1;
    kill = 1'b0; lsu.req = 1'b0; lsu.w_en = 1'b0;
    lsu_access(1'b0, 32'h0, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h5A5A_0000 || cyc != 0) begin bad++; $display("[TB] FAIL ikill_nowrite: got %h lat %0d want 5a5a0000 0", rd, cyc); end
    rc = req_cycles;
    @(negedge clk);
    dmem_sel = 1'b0;
    lsu.req = 1'b1; lsu.addr = 32'h50;
    #1;
    total++; if (rsp.ack !== 1'b0) begin bad++; $display("[TB] FAIL nosel_ack: got %b want 0", rsp.ack); end
    repeat (5) @(negedge clk);
    total++; if (req_cycles != rc || dut.r_valid[5] !== 1'b0) begin bad++; $display("[TB] FAIL nosel_idle: got %0d req cycles valid=%b want 0/0", req_cycles - rc, dut.r_valid[5]); end
    lsu.req = 1'b0;
    dmem_sel = 1'b1;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; int cyc; bit ok;
    @(negedge clk);
    lsu.req = 1'b1; lsu.w_en = 1'b0; lsu.addr = 32'h60; lsu.sel_byte = 4'h0;
    cyc = 0;
    #1;
    while (!d2m.req && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    total++; if (d2m.req !== 1'b1) begin bad++; $display("[TB] FAIL rmid_start: no mem req within bound"); end
    rst_n = 1'b0;
    #1;
    total++; if (d2m.req !== 1'b0 || dut.r_valid !== '0 || rsp.ack !== 1'b0) begin bad++; $display("[TB] FAIL rmid_async: got req=%b ack=%b or valid set", d2m.req, rsp.ack); end
    lsu.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lsu_access(1'b0, 32'h0, 32'h0, 4'h0, rd, cyc, ok);
    total++; if (rd !== 32'h5A5A_0000 || cyc == 0) begin bad++; $display("[TB] FAIL rmid_refill: got %h lat %0d want 5a5a0000 with miss", rd, cyc); end
  endtask

  initial begin
    test_reset();
    test_line_reads(32'h0, "line0");
    test_line_reads(32'h10, "line1");
    test_write_hit();
    test_evict();
    test_flush();
    test_kill();
    test_idle_kill_and_sel();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
